if_fetch_stage: RTL

Instruction-fetch stage plus IF/ID pipeline register of the pipelined RV32I core; sits directly upstream of the decode stage, whose rs1/rs2 fields feed the hazard unit.
Consumes the hazard unit's stall enables (active-high "advance") and the EX-stage redirect (PCSrc/branch target).
Drives a variable-latency instruction-memory request/ack interface.
Holds a fetched instruction while stalled and discards stale responses after a redirect.

---
 rtl/core_pkg.sv | 40 ++++
 rtl/if_id_reg.sv | 37 +++
 rtl/if_fetch_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared constants and types for the pipelined RV32I core front end.
//   XLEN       : data/address width
//   RESET_PC   : PC loaded on reset
//   NOP_INSTR  : bubble encoding (addi x0,x0,0)
//   fetch_state_e : fetch FSM states {REQ, WAIT, HOLD, DROP}
//   ifid_t        : IF/ID pipeline register payload
// ----------------------------------------------------------------------------
package core_pkg;

    localparam int unsigned     XLEN      = 32;
    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    // Empty pipeline slot: NOP encoding, zero PCs, not valid.
    function automatic ifid_t ifid_bubble();
        ifid_t b;
        b.instr    = NOP_INSTR;
        b.pc       = '0;
        b.pc_plus4 = '0;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
// Enable/flush pipeline register carrying an ifid_t payload. Reusable for
// later stage boundaries. Reset and clear both load a bubble; clear wins
// over enable.
// Ports:
//   i_clk  : clock
//   i_rst  : synchronous reset, active-high
//   i_en   : load i_d
//   i_clr  : load a bubble regardless of i_en
//   i_d    : next payload
//   o_q    : registered payload
// ----------------------------------------------------------------------------
module if_id_reg
    import core_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_en,
    input  logic  i_clr,
    input  ifid_t i_d,
    output ifid_t o_q
);

    ifid_t r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_q <= ifid_bubble();
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction fetch plus IF/ID register. Issues one request at a time to a
// variable-latency instruction memory, holds a fetched word while the
// pipeline is stalled and discards the response owed after a redirect.
// Optional macro IF_PERF_CNT_EN adds saturating perf_fetched/perf_dropped.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   pc_en, ifid_en    : hazard-unit stall enables (1 = advance)
//   flush, branch_target : EX-stage redirect
//   imem_req/addr     : request strobe and address
//   imem_ack/rdata    : response valid and instruction word
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID register contents
//   fetch_busy        : a response is outstanding (WAIT or DROP)
//   perf_fetched, perf_dropped : event counters (IF_PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module if_fetch_stage
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_en,
    input  logic            ifid_en,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            fetch_busy
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);

    fetch_state_e    r_state, w_state_d;
    logic [XLEN-1:0] r_pc_f, w_pc_d;
    // Buffer contents are meaningful only while in HOLD.
    logic [31:0]     r_buf_instr, w_buf_instr_d;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_advance;
    logic            w_ifid_load;
    ifid_t           w_ifid_next;
    ifid_t           w_ifid_q;

    assign w_advance  = pc_en & ifid_en;
    assign w_pc_plus4 = r_pc_f + XLEN'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= REQ;
            r_pc_f      <= RESET_PC;
            r_buf_instr <= NOP_INSTR;
        end else begin
            r_state     <= w_state_d;
            r_pc_f      <= w_pc_d;
            r_buf_instr <= w_buf_instr_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_pc_d        = r_pc_f;
        w_buf_instr_d = r_buf_instr;
        w_ifid_load   = 1'b0;
        w_ifid_next   = ifid_bubble();

        unique case (r_state)
            REQ: begin
                w_state_d   = WAIT;
                // Decode consumed the previous slot; refill with a bubble.
                w_ifid_load = ifid_en;
            end
            WAIT: begin
                if (imem_ack) begin
                    if (w_advance) begin
                        w_ifid_load          = 1'b1;
                        w_ifid_next.instr    = imem_rdata;
                        w_ifid_next.pc       = r_pc_f;
                        w_ifid_next.pc_plus4 = w_pc_plus4;
                        w_ifid_next.valid    = 1'b1;
                        w_pc_d               = w_pc_plus4;
                        w_state_d            = REQ;
                    end else begin
                        w_buf_instr_d = imem_rdata;
                        w_state_d     = HOLD;
                    end
                end else begin
                    w_ifid_load = ifid_en;
                end
            end
            HOLD: begin
                if (w_advance) begin
                    w_ifid_load          = 1'b1;
                    w_ifid_next.instr    = r_buf_instr;
                    w_ifid_next.pc       = r_pc_f;
                    w_ifid_next.pc_plus4 = w_pc_plus4;
                    w_ifid_next.valid    = 1'b1;
                    w_pc_d               = w_pc_plus4;
                    w_state_d            = REQ;
                end else begin
                    w_ifid_load = ifid_en;
                end
            end
            DROP: begin
                // Owed response is thrown away when it shows up.
                w_ifid_load = ifid_en;
                if (imem_ack) begin
                    w_state_d = REQ;
                end
            end
            default: begin
                w_state_d = REQ;
            end
        endcase

        // Redirect overrides everything; the IF/ID clear is done by i_clr.
        if (flush) begin
            w_pc_d      = branch_target;
            w_ifid_load = 1'b0;
            unique case (r_state)
                REQ:        w_state_d = DROP;
                HOLD:       w_state_d = REQ;
                WAIT, DROP: w_state_d = imem_ack ? REQ : DROP;
                default:    w_state_d = REQ;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .i_clk (clk),
        .i_rst (rst),
        .i_en  (w_ifid_load),
        .i_clr (flush),
        .i_d   (w_ifid_next),
        .o_q   (w_ifid_q)
    );

    assign imem_req   = (r_state == REQ) & ~rst;
    assign imem_addr  = r_pc_f;
    assign fetch_busy = (r_state == WAIT) | (r_state == DROP);
    assign instr_d    = w_ifid_q.instr;
    assign pc_d       = w_ifid_q.pc;
    assign pc_plus4_d = w_ifid_q.pc_plus4;
    assign valid_d    = w_ifid_q.valid;

`ifdef IF_PERF_CNT_EN
    logic        w_fetched;
    logic        w_dropped;
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;

    // flush forces w_ifid_load low, so a flushed load is never counted.
    assign w_fetched = w_ifid_load & w_ifid_next.valid;
    assign w_dropped = imem_ack & ((r_state == DROP) | ((r_state == WAIT) & flush));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
        end else begin
            if (w_fetched && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_dropped && (r_perf_dropped != 32'hFFFF_FFFF)) begin
                r_perf_dropped <= r_perf_dropped + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
`endif

endmodule
